uart_bus_arbiter: RTL
=====================

Name: uart_bus_arbiter

Overview:
Two-master arbiter that shares one UART register port (request/rw/address/wdata, rdata/ready handshake) between a CPU-side master and a debug/boot-monitor master. Round-robin grant, with the whole transaction held until the UART returns ready. It sits between the two bus masters and the UART, which is the single slave.

Parameters:
TIMEOUT, 1024, cycles a granted transaction may wait for i_uart_ready; used only when UART_ARB_TIMEOUT_EN is defined.
IRQ_TARGET, 0, which master receives the UART interrupt: 0 = m0, 1 = m1, 2 = both.

Ports:
i_clock  in  1  single clock, all logic rising-edge
i_reset  in  1  synchronous, active-high reset
i_m0_request  in  1  master 0 request, held until o_m0_ready
i_m0_rw  in  1  master 0 direction: 1 = write, 0 = read
i_m0_address  in  2  master 0 register address
i_m0_wdata  in  32  master 0 write data
o_m0_rdata  out  32  master 0 read data, valid while o_m0_ready is high
o_m0_ready  out  1  master 0 one-cycle completion pulse
o_m0_interrupt  out  1  UART interrupt routed to master 0
i_m1_request, i_m1_rw, i_m1_address, i_m1_wdata, o_m1_rdata, o_m1_ready, o_m1_interrupt: same as master 0, for master 1
o_uart_request  out  1  request to UART
o_uart_rw  out  1  registered rw of the granted master
o_uart_address  out  2  registered address of the granted master
o_uart_wdata  out  32  registered wdata of the granted master
i_uart_rdata  in  32  UART read data
i_uart_ready  in  1  UART completion
i_uart_interrupt  in  1  UART interrupt
o_timeout  out  1  one-cycle pulse when a transaction is aborted; tied 0 without the macro

Behaviour:
- Reset: i_clock rising edge with i_reset=1.
  - State goes to IDLE; last_grant=1, so m0 wins the first tie.
  - All o_* outputs are 0, including latched rdata/rw/address/wdata.
  - Reset mid-transaction abandons it; no ready pulse is issued to either master.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - o_uart_request=0.
  - If exactly one master requests, grant it.
  - If both request, grant the one != last_grant.
  - On grant: latch that master's rw/address/wdata and its index into registers, set last_grant=index, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - o_uart_request=1; o_uart_rw/address/wdata come from the latched registers.
  - Changes on master inputs are ignored.
  - On i_uart_ready=1: latch i_uart_rdata and go to DONE. o_uart_request drops in the next cycle.
- DONE (exactly one cycle):
  - o_mX_ready=1 for the granted master only; o_mX_rdata = latched rdata.
  - The non-granted master sees ready=0 and rdata=0; o_uart_request=0.
  - Next state is IDLE.
- Master rule: deassert request in the cycle after o_mX_ready. IDLE samples requests in that cycle, so a request still held there is treated as a new transaction.
- Latency:
  - Request seen in IDLE at cycle 0 -> o_uart_request high from cycle 1.
  - UART ready at cycle k -> o_mX_ready at cycle k+1 -> next grant possible at cycle k+2.
  - Minimum 3 cycles per transaction when the UART is ready in cycle 1.
- Fairness: under continuous requests from both masters, grants alternate strictly m0, m1, m0, …
- rdata on writes: passed through unchanged; the master ignores it.
- Interrupt: combinational fan-out of i_uart_interrupt per IRQ_TARGET; the other master's output is 0. Unaffected by arbiter state and not reset-gated beyond the input itself.
- i_uart_ready outside BUSY is ignored.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle without ready.
  - If TIMEOUT cycles elapse without i_uart_ready, force DONE with latched rdata=32'hFFFF_FFFF and pulse o_timeout in the DONE cycle.
  - Ready arriving in the same cycle the limit is reached wins: normal completion, no timeout.
  - Counter width is $clog2(TIMEOUT+1).
- Undefined: no counter; BUSY waits indefinitely; o_timeout is constant 0.

Test Plan:
- Reset, then m0 read addr=2; UART returns rdata=32'h0000_0041 with ready two cycles after o_uart_request rises -> o_m0_ready pulses one cycle with rdata 32'h41; m1 outputs stay 0.
- m0 and m1 request in the same IDLE cycle after reset -> m0 granted first, then m1. Both held continuously for 4 transactions -> grant order m0, m1, m0, m1.
- m1 write wdata=32'h55 addr=0 and BUSY entered; m1 changes wdata to 32'hAA mid-BUSY -> o_uart_wdata stays 32'h55 until ready.
- Assert i_reset during BUSY -> next cycle o_uart_request=0, no ready pulse to either master; a fresh m1 request afterwards is served normally.
- i_uart_ready pulsed while IDLE -> no state change, no master ready. i_uart_interrupt=1 with IRQ_TARGET=2 -> both o_m0_interrupt and o_m1_interrupt=1.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=8, UART never ready -> o_m0_ready and o_timeout pulse together 8 cycles after BUSY entry with rdata 32'hFFFF_FFFF. Ready on cycle 8 exactly -> normal rdata, o_timeout=0.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin arbiter sharing one UART register port between two masters.
// Optional abort of stalled transactions when UART_ARB_TIMEOUT_EN is defined.
module uart_bus_arbiter #(
    parameter int TIMEOUT    = 1024,
    parameter int IRQ_TARGET = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_m0_request,
    input  logic        i_m0_rw,
    input  logic [1:0]  i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_ready,
    output logic        o_m0_interrupt,
    input  logic        i_m1_request,
    input  logic        i_m1_rw,
    input  logic [1:0]  i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_ready,
    output logic        o_m1_interrupt,
    output logic        o_uart_request,
    output logic        o_uart_rw,
    output logic [1:0]  o_uart_address,
    output logic [31:0] o_uart_wdata,
    input  logic [31:0] i_uart_rdata,
    input  logic        i_uart_ready,
    input  logic        i_uart_interrupt,
    output logic        o_timeout
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic        last_q;
    logic        gnt_q;
    logic        rw_q;
    logic [1:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        sel;
    logic        expire;

    // On a tie the master that did not win last time is served
    assign sel = (i_m0_request && i_m1_request) ? ~last_q : i_m1_request;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_m0_request || i_m1_request) begin
                    gnt_q   <= sel;
                    last_q  <= sel;
                    rw_q    <= sel ? i_m1_rw : i_m0_rw;
                    addr_q  <= sel ? i_m1_address : i_m0_address;
                    wdata_q <= sel ? i_m1_wdata : i_m0_wdata;
                    state_q <= BUSY;
                end
                BUSY: if (i_uart_ready) begin
                    rdata_q <= i_uart_rdata;
                    state_q <= DONE;
                end else if (expire) begin
                    rdata_q <= '1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_uart_request = state_q == BUSY;
    assign o_uart_rw      = rw_q;
    assign o_uart_address = addr_q;
    assign o_uart_wdata   = wdata_q;
    assign o_m0_ready     = state_q == DONE && !gnt_q;
    assign o_m1_ready     = state_q == DONE && gnt_q;
    assign o_m0_rdata     = o_m0_ready ? rdata_q : '0;
    assign o_m1_rdata     = o_m1_ready ? rdata_q : '0;
    assign o_m0_interrupt = i_uart_interrupt && (IRQ_TARGET != 1);
    assign o_m1_interrupt = i_uart_interrupt && (IRQ_TARGET != 0);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          tmo_q;

    // Abort on the TIMEOUT-th busy cycle without ready; a ready in that cycle still wins
    assign expire = cnt_q == CW'(TIMEOUT - 1);

    always_ff @(posedge i_clock) begin
        if (i_reset || state_q != BUSY)
            cnt_q <= '0;
        else if (!i_uart_ready)
            cnt_q <= cnt_q + 1'b1;
        tmo_q <= !i_reset && state_q == BUSY && !i_uart_ready && expire;
    end

    assign o_timeout = tmo_q;
`else
    // Never true for a legal TIMEOUT, so BUSY waits for ready indefinitely
    assign expire    = TIMEOUT < 0;
    assign o_timeout = 1'b0;
`endif
endmodule
